// File: rtl/gpr_file_sb.sv
// gpr_file_sb: parametrised MIPS GPR file with two combinational read ports,
//    one posedge write port, and a per-register pending-write scoreboard for
//    RAW hazard detection in ID.
// Optional feature macro: GPR_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    rs_addr/rs_data       read port A (address in, combinational data out)
//    rt_addr/rt_data       read port B
//    wr_en/wr_addr/wr_data WB write port; each write also retires one pending write
//    iss_en/iss_addr       ID issue of an instruction that will write iss_addr
//    rs_busy/rt_busy       read address has an outstanding, not yet visible write
//    hazard                rs_busy | rt_busy
//    sb_err                sticky scoreboard overflow/underflow flag
module gpr_file_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int PEND_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              rs_busy,
   output logic              rt_busy,
   output logic              hazard,
   output logic              sb_err
);
   // Arrays span the full address space; entries at r0 and beyond NUM_REGS are
   // never written, so they read back as constant zero and never look busy.
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [PEND_W-1:0] cnt_q [DEPTH];
   logic [PEND_W-1:0] cnt_d [DEPTH];
   logic              sb_err_q, sb_err_d;
   logic              wr_ok, iss_ok, rs_fwd, rt_fwd;
   logic [DEPTH-1:0]  inc, dec;
   // Gating with rst_n keeps forwarding and busy quiet while reset is held.
   assign wr_ok  = rst_n && wr_en && wr_addr != '0 && int'(wr_addr) < NUM_REGS;
   assign iss_ok = rst_n && iss_en && iss_addr != '0 && int'(iss_addr) < NUM_REGS;
   assign inc    = iss_ok ? {{(DEPTH-1){1'b0}}, 1'b1} << iss_addr : '0;
   assign dec    = wr_ok  ? {{(DEPTH-1){1'b0}}, 1'b1} << wr_addr  : '0;
`ifdef GPR_BYPASS_EN
   assign rs_fwd = wr_ok && wr_addr == rs_addr;
   assign rt_fwd = wr_ok && wr_addr == rt_addr;
`else
   assign rs_fwd = 1'b0;
   assign rt_fwd = 1'b0;
`endif
   always_comb begin
      sb_err_d = sb_err_q;
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = dec[i] ? wr_data : regs_q[i];
         cnt_d[i]  = cnt_q[i];
         // Simultaneous issue and retire cancel; saturate and flag on the rest.
         if (inc[i] && !dec[i]) begin
            if (cnt_q[i] == CNT_MAX) sb_err_d = 1'b1;
            else cnt_d[i] = cnt_q[i] + PEND_W'(1);
         end else if (dec[i] && !inc[i]) begin
            if (cnt_q[i] == '0) sb_err_d = 1'b1;
            else cnt_d[i] = cnt_q[i] - PEND_W'(1);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         cnt_q    <= cnt_d;
         sb_err_q <= sb_err_d;
      end
   end
   // A forwarded retire is already visible on the data port, so it no longer counts as pending.
   assign rs_data = rs_fwd ? wr_data : regs_q[rs_addr];
   assign rt_data = rt_fwd ? wr_data : regs_q[rt_addr];
   assign rs_busy = (cnt_q[rs_addr] - PEND_W'(rs_fwd)) != '0;
   assign rt_busy = (cnt_q[rt_addr] - PEND_W'(rt_fwd)) != '0;
   assign hazard  = rs_busy | rt_busy;
   assign sb_err  = sb_err_q;
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed checks of reset, r0, write/read, bypass and scoreboard.
module tb_gpr_file_sb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr, wr_addr, iss_addr;
   logic [31:0] rs_data, rt_data, wr_data;
   logic        wr_en, iss_en, rs_busy, rt_busy, hazard, sb_err;
   int          n_vec = 0;
   int          n_err = 0;
`ifdef GPR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   gpr_file_sb dut (
      .clk(clk), .rst_n(rst_n),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .rs_busy(rs_busy), .rt_busy(rt_busy), .hazard(hazard), .sb_err(sb_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
   endtask
   task automatic issue(input logic [4:0] a);
      iss_en = 1'b1; iss_addr = a; wr_en = 1'b0;
      tick();
      idle();
   endtask
   task automatic retire(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d; iss_en = 1'b0;
      tick();
      idle();
   endtask
   initial begin
      rst_n = 1'b0; rs_addr = 5'd5; rt_addr = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      iss_en = 1'b0; iss_addr = 5'd0;
      // 1. reset held with a write pending on the port
      repeat (3) tick();
      chk("rst_hold_rs_data", rs_data, 32'h0);
      chk("rst_hold_rs_busy", {31'b0, rs_busy}, 32'h0);
      chk("rst_hold_sb_err", {31'b0, sb_err}, 32'h0);
      rst_n = 1'b1; idle();
      tick();
      chk("rst_rel_r5", rs_data, 32'h0);
      chk("rst_rel_sb_err", {31'b0, sb_err}, 32'h0);
      // 2. r0 protection
      rs_addr = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      iss_en = 1'b1; iss_addr = 5'd0;
      #1 chk("r0_same_cycle", rs_data, 32'h0);
      tick(); idle();
      chk("r0_data", rs_data, 32'h0);
      chk("r0_busy", {31'b0, rs_busy}, 32'h0);
      chk("r0_sb_err", {31'b0, sb_err}, 32'h0);
      // 3. write/read with optional bypass (issue first so the retire is legal)
      rs_addr = 5'd3;
      issue(5'd3);
      chk("r3_busy_issued", {31'b0, rs_busy}, 32'h1);
      chk("r3_hazard", {31'b0, hazard}, 32'h1);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
      #1;
      chk("r3_same_cycle_data", rs_data, BYP ? 32'h12345678 : 32'h0);
      chk("r3_same_cycle_busy", {31'b0, rs_busy}, BYP ? 32'h0 : 32'h1);
      tick(); idle();
      chk("r3_after_edge", rs_data, 32'h12345678);
      chk("r3_busy_after", {31'b0, rs_busy}, 32'h0);
      // 4. scoreboard on r7 via port B
      rt_addr = 5'd7;
      #1 chk("r7_idle_busy", {31'b0, rt_busy}, 32'h0);
      issue(5'd7);
      chk("r7_busy_1", {31'b0, rt_busy}, 32'h1);
      issue(5'd7);
      chk("r7_busy_2", {31'b0, rt_busy}, 32'h1);
      retire(5'd7, 32'h00000077);
      chk("r7_busy_after_ret1", {31'b0, rt_busy}, 32'h1);
      chk("r7_data_ret1", rt_data, 32'h00000077);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000088;
      #1;
      chk("r7_busy_in_ret2", {31'b0, rt_busy}, BYP ? 32'h0 : 32'h1);
      chk("r7_data_in_ret2", rt_data, BYP ? 32'h00000088 : 32'h00000077);
      tick(); idle();
      chk("r7_busy_after_ret2", {31'b0, rt_busy}, 32'h0);
      chk("r7_data_ret2", rt_data, 32'h00000088);
      chk("rs_r3_kept", rs_data, 32'h12345678);
      // 5. simultaneous issue and retire on r9
      rs_addr = 5'd9;
      issue(5'd9);
      iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      tick(); idle();
      chk("r9_busy_sim", {31'b0, rs_busy}, 32'h1);
      chk("r9_sb_err_sim", {31'b0, sb_err}, 32'h0);
      chk("r9_data_sim", rs_data, 32'h99);
      retire(5'd9, 32'h9A);
      chk("r9_busy_drain", {31'b0, rs_busy}, 32'h0);
      chk("r9_sb_err_drain", {31'b0, sb_err}, 32'h0);
      // 6a. underflow is sticky across later traffic
      rs_addr = 5'd4;
      retire(5'd4, 32'h44);
      chk("underflow_err", {31'b0, sb_err}, 32'h1);
      chk("underflow_busy", {31'b0, rs_busy}, 32'h0);
      chk("underflow_data", rs_data, 32'h44);
      issue(5'd4);
      retire(5'd4, 32'h45);
      chk("underflow_sticky", {31'b0, sb_err}, 32'h1);
      // async reset pulse mid-operation
      issue(5'd4);
      rt_addr = 5'd3;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pulse_err", {31'b0, sb_err}, 32'h0);
      chk("rst_pulse_busy", {31'b0, rs_busy}, 32'h0);
      chk("rst_pulse_r3", rt_data, 32'h0);
      rst_n = 1'b1;
      tick();
      // 6b. saturation at 3 pending writes
      issue(5'd4); issue(5'd4); issue(5'd4);
      chk("sat_3_no_err", {31'b0, sb_err}, 32'h0);
      issue(5'd4);
      chk("sat_4_err", {31'b0, sb_err}, 32'h1);
      retire(5'd4, 32'h1); retire(5'd4, 32'h2);
      chk("sat_drain_2_busy", {31'b0, rs_busy}, 32'h1);
      retire(5'd4, 32'h3);
      chk("sat_drain_3_busy", {31'b0, rs_busy}, 32'h0);
      chk("sat_drain_data", rs_data, 32'h3);
      chk("sat_err_sticky", {31'b0, sb_err}, 32'h1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the pipelined MIPS core, generalising the fixed 32x32 GPR.
- Two combinational read ports (rs, rt) serve the ID stage; one write port is driven by WB.
- Adds asynchronous clear, posedge write, optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard that ID uses for RAW stall detection.
- Destination decoding (rd/rt/ra) is done upstream; this block receives a resolved write address.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of registers; register 0 is hardwired zero
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS
PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2**PEND_W-1

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rs_addr  in  ADDR_W  read port A address (ID instr[25:21])
rt_addr  in  ADDR_W  read port B address (ID instr[20:16])
rs_data  out  DATA_W  read port A data, combinational
rt_data  out  DATA_W  read port B data, combinational
wr_en  in  1  WB write strobe; also retires one pending write for wr_addr
wr_addr  in  ADDR_W  WB destination register
wr_data  in  DATA_W  WB write data
iss_en  in  1  ID issues an instruction that will write iss_addr
iss_addr  in  ADDR_W  destination of the issuing instruction
rs_busy  out  1  rs_addr has an outstanding write not yet visible on rs_data
rt_busy  out  1  same for rt_addr
hazard  out  1  rs_busy | rt_busy
sb_err  out  1  sticky scoreboard over/underflow flag

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all pending counters 0, sb_err 0. Reads return 0 and busy flags are 0 while reset is held.
- Write: on posedge clk, if wr_en and wr_addr != 0 and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data.
  - Writes to r0 or to out-of-range addresses are ignored; they have no data effect and no scoreboard effect.
- Read: rs_data/rt_data are combinational.
  - Address 0 or an out-of-range address returns 0.
  - Without bypass, a value written at edge N is visible after edge N.
- Scoreboard, per register i in 1..NUM_REGS-1, counter cnt[i] updated on posedge clk:
  - inc = iss_en & iss_addr==i; dec = wr_en & wr_addr==i.
  - inc & !dec: cnt+1. If cnt is already at max, cnt holds and sb_err <= 1.
  - dec & !inc: cnt-1. If cnt is already 0, cnt holds and sb_err <= 1.
  - inc & dec in the same cycle: cnt unchanged (issue and retire cancel); never an error.
  - r0: issues and retires to r0 are ignored; cnt[0] stays 0.
- sb_err is sticky until reset.
- Busy (combinational):
  - Without bypass: rs_busy = cnt[rs_addr] != 0.
  - With bypass: rs_busy = (cnt[rs_addr] - (wr_en & wr_addr==rs_addr)) != 0.
  - rt_busy is defined the same way on rt_addr. Address 0 is never busy.
- The issue in the current cycle does not affect busy; the caller must stall before asserting iss_en.
- Issue to a busy destination (WAW) is legal; the counter tracks multiple in-flight writes.
- Reset asserted mid-operation: all pending state is discarded immediately; outputs return to their reset values.

Optional Feature:
GPR_BYPASS_EN
- Defined: when wr_en and wr_addr == rs_addr != 0, rs_data = wr_data in the same cycle (rt_data likewise), and busy subtracts the in-cycle retire as described in Behaviour.
- Undefined: no forwarding; reads show only registered contents, and busy = cnt != 0.
- Writes still occur on posedge in both cases; this replaces the legacy negedge-write trick.

Test Plan:
1. Reset: hold rst_n=0 with wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF for 3 clocks, then release; read r5 -> 0, rs_busy=0, sb_err=0.
2. r0 protection: wr_en, wr_addr=0, wr_data=32'hFFFFFFFF; iss_en, iss_addr=0 -> rs_addr=0 reads 0, rs_busy=0, sb_err=0.
3. Write/read and bypass: write r3=32'h12345678 with rs_addr=3 in the same cycle.
   - Bypass build: rs_data=32'h12345678 in that cycle.
   - Non-bypass build: the old value in that cycle, 32'h12345678 after the edge.
4. Scoreboard:
   - Issue r7 twice -> cnt=2, rt_busy=1 with rt_addr=7.
   - Retire once -> still busy.
   - Retire again -> rt_busy=0 after the edge (same cycle in the bypass build).
5. Simultaneous events: cnt[9]=1, then iss_en and wr_en both to r9 in one cycle -> cnt stays 1, rs_busy=1, sb_err=0.
6. Errors:
   - Retire r4 with cnt=0 -> sb_err=1, which stays 1 across later traffic until rst_n is pulsed.
   - Issue r4 four times with PEND_W=2 -> cnt saturates at 3 and sb_err=1.
